// File: rtl/spi_byte_streamer.sv
// Streams bytes through a register-mapped SPI master, one byte in flight at a time.
// Optional WAIT_RX abort timer is enabled with `define SPI_STREAM_TIMEOUT_EN.
module spi_byte_streamer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        spi_select,
  output logic [2:0]  spi_mem_addr,
  output logic        spi_write_n,
  output logic        spi_read_n,
  output logic [15:0] spi_data_from_cpu,
  input  logic [15:0] spi_data_to_cpu,
  input  logic        spi_dataavailable,
  input  logic        spi_readyfordata,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, SSO_ON, WR_TX, WAIT_RX, RD_RX, OUT, SSO_OFF
  } state_t;

  state_t      state, state_next;
  logic [1:0]  step, step_next;
  logic        pkt_open;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_byte;
  logic        last_q;
  logic        access_state;
  logic        go;
  logic        active;
  logic        timeout_hit;
  logic        unused_hi;

  assign unused_hi = ^spi_data_to_cpu[15:8];

  // Each access walks step 0,1 (selected) then step 2 (deselected gap).
  // WR_TX parks in step 0 with the bus idle until the core has TX room.
  assign access_state = (state == SSO_ON) || (state == WR_TX) ||
                        (state == RD_RX)  || (state == SSO_OFF);
  assign go     = access_state &&
                  !((state == WR_TX) && (step == 2'd0) && !spi_readyfordata);
  assign active = go && (step != 2'd2);

`ifdef SPI_STREAM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)               wait_cnt <= '0;
    else if (state == WAIT_RX)  wait_cnt <= wait_cnt + 8'd1;
    else                        wait_cnt <= '0;
  end

  assign timeout_hit = (state == WAIT_RX) && !spi_dataavailable &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    step_next  = step;
    case (state)
      IDLE:    if (in_valid) state_next = pkt_open ? WR_TX : SSO_ON;
      SSO_ON, WR_TX, RD_RX, SSO_OFF: begin
        if (go) begin
          if (step == 2'd2) begin
            step_next = 2'd0;
            case (state)
              SSO_ON:  state_next = WR_TX;
              WR_TX:   state_next = WAIT_RX;
              RD_RX:   state_next = OUT;
              default: state_next = IDLE;
            endcase
          end else begin
            step_next = step + 2'd1;
          end
        end
      end
      WAIT_RX: begin
        if (spi_dataavailable) state_next = RD_RX;
        else if (timeout_hit)  state_next = SSO_OFF;
      end
      OUT:     if (out_ready) state_next = last_q ? SSO_OFF : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      step     <= 2'd0;
      pkt_open <= 1'b0;
      tx_byte  <= 8'h00;
      last_q   <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      state <= state_next;
      step  <= step_next;
      if ((state == IDLE) && in_valid) begin
        tx_byte <= in_data;
        last_q  <= in_last;
      end
      // Read data lags the address by one cycle, so it is valid on the second access cycle.
      if ((state == RD_RX) && (step == 2'd1)) rx_byte <= spi_data_to_cpu[7:0];
      if ((state == SSO_ON) && (step == 2'd2))  pkt_open <= 1'b1;
      if ((state == SSO_OFF) && (step == 2'd2)) pkt_open <= 1'b0;
    end
  end

  always_comb begin
    spi_select        = active;
    spi_write_n       = 1'b1;
    spi_read_n        = 1'b1;
    spi_mem_addr      = 3'd0;
    spi_data_from_cpu = 16'h0000;
    if (active) begin
      case (state)
        SSO_ON: begin
          spi_write_n       = 1'b0;
          spi_mem_addr      = 3'd3;
          spi_data_from_cpu = 16'h0400;
        end
        WR_TX: begin
          spi_write_n       = 1'b0;
          spi_mem_addr      = 3'd1;
          spi_data_from_cpu = {8'h00, tx_byte};
        end
        RD_RX: begin
          spi_read_n   = 1'b0;
          spi_mem_addr = 3'd0;
        end
        default: begin
          spi_write_n  = 1'b0;
          spi_mem_addr = 3'd3;
        end
      endcase
    end
  end

  assign in_ready    = reset_n && (state == IDLE);
  assign out_valid   = (state == OUT);
  assign out_data    = rx_byte;
  assign out_last    = last_q;
  assign busy        = (state != IDLE);
  assign timeout_err = timeout_hit;

endmodule
